lsq_mem_issue: RTL and testbench
================================

LSQ_MEM_ISSUE -- requirements
Module: lsq_mem_issue

Interface
REQ-001 Parameter SHALL be ROB_ID_W, default 6, the ROB index width.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-004 flush  in  1  SHALL be the pipeline flush; it aborts the in-flight op.
REQ-005 head_valid  in  1  SHALL indicate the LSQ head entry is valid.
REQ-006 head_is_store / head_addr_valid / head_unsigned  in  1 each  SHALL give the head op type, address-resolved flag and unsigned-load flag.
REQ-007 head_addr, head_data  in  32 each; head_size  in  2 (0 byte, 1 half, 2 word); head_rob_id  in  ROB_ID_W  SHALL carry the head entry fields.
REQ-008 deq_valid  out  1  SHALL be a one-cycle pop of the LSQ head.
REQ-009 store_commit  in  1; store_commit_rob_id  in  ROB_ID_W  SHALL give ROB permission to perform the committing store.
REQ-010 dc_req_valid  out  1; dc_req_ready  in  1; dc_req_we  out  1; dc_req_addr, dc_req_wdata  out  32; dc_req_be  out  4  SHALL form the D-cache request channel.
REQ-011 dc_resp_valid  in  1; dc_resp_rdata  in  32  SHALL form the load response channel (no backpressure, one response per load request).
REQ-012 wb_valid  out  1; wb_rob_id  out  ROB_ID_W; wb_data  out  32  SHALL be the load writeback port.
REQ-013 busy  out  1  SHALL be high whenever state != IDLE.

Function
REQ-014 FSM states SHALL be IDLE, REQ, WAIT, WB, DRAIN; fields captured into internal registers on leaving IDLE.
REQ-015 IDLE->REQ SHALL occur when head_valid & head_addr_valid & (!head_is_store | (store_commit & store_commit_rob_id == head_rob_id)).
REQ-016 In REQ, dc_req_valid SHALL be 1 and all dc_req_* SHALL stay stable from captured registers until dc_req_ready.
REQ-017 Store handshake SHALL pulse deq_valid in the handshake cycle and go to IDLE; stores get no response.
REQ-018 Load handshake SHALL go to WAIT; dc_resp_valid in WAIT SHALL register formatted data and go to WB.
REQ-019 In WB, wb_valid and deq_valid SHALL pulse together for one cycle with the captured rob_id, then IDLE.
REQ-020 Load latency SHALL be exactly 1 cycle from dc_resp_valid to wb_valid.
REQ-021 After any deq_valid the block SHALL spend at least one cycle in IDLE before re-evaluating head.
REQ-022 dc_req_addr SHALL be the captured address with low bits cleared to size alignment; dc_req_wdata SHALL replicate the store byte/half across all lanes.
REQ-023 Flush in IDLE, WB or REQ without handshake SHALL go to IDLE next cycle with no deq_valid/wb_valid.
REQ-024 Flush coincident with a store handshake SHALL let the store complete but suppress deq_valid.
REQ-025 Flush coincident with a load handshake, or in WAIT without dc_resp_valid, SHALL go to DRAIN.
REQ-026 Flush in WAIT coincident with dc_resp_valid SHALL discard the data and go to IDLE.
REQ-027 DRAIN SHALL discard the next dc_resp_valid and then go to IDLE; flush while in DRAIN SHALL be ignored.

Reset
REQ-028 rst SHALL force IDLE and drive deq_valid, dc_req_valid, dc_req_we, wb_valid, busy = 0 and dc_req_addr, dc_req_wdata, dc_req_be, wb_data, wb_rob_id = 0 on the next edge.
REQ-029 rst mid-operation SHALL abandon any outstanding request; rst has priority over flush.

Configuration
REQ-030 With LSQ_ISSUE_SUBWORD_EN defined, head_size/head_unsigned SHALL be honoured: dc_req_be per size and addr[1:0], load lane extracted and sign/zero extended.
REQ-031 Without LSQ_ISSUE_SUBWORD_EN, all accesses SHALL be word: dc_req_be = 4'hF, addr[1:0] forced 0, wb_data = dc_resp_rdata raw, head_size/head_unsigned ignored.

Verification
REQ-032 Load addr 0x1000 rob 5, dc_req_ready immediate, resp 0xDEADBEEF two cycles later -> wb_valid one cycle after resp with rob 5, data 0xDEADBEEF, deq_valid same cycle.
REQ-033 Store addr 0x2004 data 0xAB size byte rob 3, store_commit rob 3 -> dc_req_we=1, be=4'b0001, wdata=0xABABABAB, deq_valid on handshake (SUBWORD_EN).
REQ-034 Store head rob 3, store_commit rob 4 for 10 cycles -> no dc_req_valid, busy=0.
REQ-035 Load signed byte addr 0x103, rdata 0x80000000 -> wb_data 0xFFFFFF80; unsigned -> 0x00000080 (SUBWORD_EN).
REQ-036 Load in WAIT, flush, resp 3 cycles later -> DRAIN, no wb_valid/deq_valid, then IDLE.
REQ-037 dc_req_ready low 4 cycles with rst asserted in cycle 2 -> dc_req_valid 0 from the next edge onward, state IDLE.

Source files
------------

// File: rtl/lsq_mem_issue.sv
// LSQ head issue engine: sends the head op to the D-cache and writes back load data.
// Define LSQ_ISSUE_SUBWORD_EN for byte/half accesses; the default build issues word accesses only.
module lsq_mem_issue #(
  parameter int unsigned ROB_ID_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                head_valid,
  input  logic                head_is_store,
  input  logic                head_addr_valid,
  input  logic                head_unsigned,
  input  logic [31:0]         head_addr,
  input  logic [31:0]         head_data,
  input  logic [1:0]          head_size,
  input  logic [ROB_ID_W-1:0] head_rob_id,
  output logic                deq_valid,
  input  logic                store_commit,
  input  logic [ROB_ID_W-1:0] store_commit_rob_id,
  output logic                dc_req_valid,
  input  logic                dc_req_ready,
  output logic                dc_req_we,
  output logic [31:0]         dc_req_addr,
  output logic [31:0]         dc_req_wdata,
  output logic [3:0]          dc_req_be,
  input  logic                dc_resp_valid,
  input  logic [31:0]         dc_resp_rdata,
  output logic                wb_valid,
  output logic [ROB_ID_W-1:0] wb_rob_id,
  output logic [31:0]         wb_data,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, DRAIN} state_t;

  state_t      state, state_n;
  logic        issue_go;
  logic [31:0] fmt_addr;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_load;

  assign issue_go = head_valid & head_addr_valid &
                    (!head_is_store | (store_commit & (store_commit_rob_id == head_rob_id)));

`ifdef LSQ_ISSUE_SUBWORD_EN
  logic [1:0]  cap_size;
  logic [1:0]  cap_off;
  logic        cap_unsigned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    fmt_addr  = head_addr;
    fmt_be    = 4'hF;
    fmt_wdata = head_data;
    case (head_size)
      2'd0: begin
        fmt_be    = 4'b0001 << head_addr[1:0];
        fmt_wdata = {4{head_data[7:0]}};
      end
      2'd1: begin
        fmt_addr[0] = 1'b0;
        fmt_be      = head_addr[1] ? 4'b1100 : 4'b0011;
        fmt_wdata   = {2{head_data[15:0]}};
      end
      default: fmt_addr[1:0] = 2'b00;
    endcase
  end

  // Lane select uses the offset captured at issue, not the live head.
  always_comb begin
    ld_byte  = dc_resp_rdata[7:0];
    ld_half  = cap_off[1] ? dc_resp_rdata[31:16] : dc_resp_rdata[15:0];
    fmt_load = dc_resp_rdata;
    case (cap_off)
      2'd1:    ld_byte = dc_resp_rdata[15:8];
      2'd2:    ld_byte = dc_resp_rdata[23:16];
      2'd3:    ld_byte = dc_resp_rdata[31:24];
      default: ld_byte = dc_resp_rdata[7:0];
    endcase
    case (cap_size)
      2'd0:    fmt_load = {{24{~cap_unsigned & ld_byte[7]}}, ld_byte};
      2'd1:    fmt_load = {{16{~cap_unsigned & ld_half[15]}}, ld_half};
      default: fmt_load = dc_resp_rdata;
    endcase
  end
`else
  logic unused_subword;

  assign fmt_addr       = {head_addr[31:2], 2'b00};
  assign fmt_be         = 4'hF;
  assign fmt_wdata      = head_data;
  assign fmt_load       = dc_resp_rdata;
  assign unused_subword = ^{head_size, head_unsigned, head_addr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    deq_valid = 1'b0;
    wb_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && issue_go) state_n = REQ;
      end
      REQ: begin
        if (dc_req_ready) begin
          if (dc_req_we) begin
            // A store already accepted by the cache completes even under flush.
            deq_valid = !flush;
            state_n   = IDLE;
          end else begin
            state_n = flush ? DRAIN : WAIT;
          end
        end else if (flush) begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (dc_resp_valid) state_n = flush ? IDLE : WB;
        else if (flush)    state_n = DRAIN;
      end
      WB: begin
        wb_valid  = !flush;
        deq_valid = !flush;
        state_n   = IDLE;
      end
      DRAIN: begin
        if (dc_resp_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign dc_req_valid = (state == REQ);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      dc_req_we    <= 1'b0;
      dc_req_addr  <= '0;
      dc_req_wdata <= '0;
      dc_req_be    <= '0;
      wb_rob_id    <= '0;
      wb_data      <= '0;
`ifdef LSQ_ISSUE_SUBWORD_EN
      cap_size     <= '0;
      cap_off      <= '0;
      cap_unsigned <= 1'b0;
`endif
    end else begin
      if (state == IDLE && !flush && issue_go) begin
        dc_req_we    <= head_is_store;
        dc_req_addr  <= fmt_addr;
        dc_req_wdata <= fmt_wdata;
        dc_req_be    <= fmt_be;
        wb_rob_id    <= head_rob_id;
`ifdef LSQ_ISSUE_SUBWORD_EN
        cap_size     <= head_size;
        cap_off      <= head_addr[1:0];
        cap_unsigned <= head_unsigned;
`endif
      end
      if (state == WAIT && dc_resp_valid && !flush) begin
        wb_data <= fmt_load;
      end
    end
  end

endmodule

// File: tb/tb_lsq_mem_issue.sv
// Self-checking bench for lsq_mem_issue: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_lsq_mem_issue;
  localparam int unsigned RW = 6;
`ifdef LSQ_ISSUE_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, head_valid, head_is_store, head_addr_valid, head_unsigned;
  logic [31:0]   head_addr, head_data;
  logic [1:0]    head_size;
  logic [RW-1:0] head_rob_id;
  logic          deq_valid, store_commit;
  logic [RW-1:0] store_commit_rob_id;
  logic          dc_req_valid, dc_req_ready, dc_req_we;
  logic [31:0]   dc_req_addr, dc_req_wdata;
  logic [3:0]    dc_req_be;
  logic          dc_resp_valid;
  logic [31:0]   dc_resp_rdata;
  logic          wb_valid;
  logic [RW-1:0] wb_rob_id;
  logic [31:0]   wb_data;
  logic          busy;

  lsq_mem_issue #(.ROB_ID_W(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .head_valid(head_valid), .head_is_store(head_is_store), .head_addr_valid(head_addr_valid),
    .head_unsigned(head_unsigned), .head_addr(head_addr), .head_data(head_data),
    .head_size(head_size), .head_rob_id(head_rob_id), .deq_valid(deq_valid),
    .store_commit(store_commit), .store_commit_rob_id(store_commit_rob_id),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_we(dc_req_we),
    .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_be(dc_req_be),
    .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_data(wb_data), .busy(busy)
  );

  typedef struct {
    bit            st;
    bit            uns;
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [1:0]    size;
    logic [RW-1:0] rob;
  } op_t;

  op_t q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: one op in flight, tracked by what it still needs from the outside world.
  bit            m_active, m_hs, m_await, m_wb, m_drop;
  op_t           m_op;
  bit            m_req_we;
  logic [31:0]   m_req_addr, m_req_wdata, m_wb_data;
  logic [3:0]    m_req_be;
  logic [RW-1:0] m_rob;
  bit            rand_mode;
  int            resp_delay;

  bit            s_deq, s_reqv, s_wbv, s_busy, s_we;
  logic [31:0]   s_addr, s_wdata, s_wbd;
  logic [3:0]    s_be;
  logic [RW-1:0] s_wbrob;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned nbytes(logic [1:0] sz);
    if (SUBWORD && sz == 2'd0) return 1;
    if (SUBWORD && sz == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_addr(logic [31:0] a, logic [1:0] sz);
    return a - (a % nbytes(sz));
  endfunction

  function automatic logic [3:0] exp_be(logic [31:0] a, logic [1:0] sz);
    int unsigned lanes = (32'd1 << nbytes(sz)) - 1;
    return 4'(lanes << (exp_addr(a, sz) % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(logic [31:0] d, logic [1:0] sz);
    case (nbytes(sz))
      1:       return (d & 32'hFF) * 32'h01010101;
      2:       return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(logic [31:0] r, logic [31:0] a, logic [1:0] sz, bit uns);
    int unsigned n = nbytes(sz);
    logic [31:0] mask, lane;
    if (n == 4) return r;
    mask = (32'd1 << (8 * n)) - 1;
    lane = (r >> (8 * (exp_addr(a, sz) % 4))) & mask;
    if (!uns && lane > (mask >> 1)) lane = lane | ~mask;
    return lane;
  endfunction

  task automatic model_reset();
    m_active = 0; m_hs = 0; m_await = 0; m_wb = 0; m_drop = 0;
    m_req_we = 0; m_req_addr = '0; m_req_wdata = '0; m_req_be = '0;
    m_wb_data = '0; m_rob = '0; resp_delay = -1;
  endtask

  task automatic model_update();
    if (m_drop) begin
      if (dc_resp_valid) m_drop = 0;
    end else if (!m_active) begin
      if (!flush && head_valid && head_addr_valid &&
          (!head_is_store || (store_commit && store_commit_rob_id == head_rob_id))) begin
        m_active = 1; m_hs = 1;
        m_op = '{st: head_is_store, uns: head_unsigned, addr: head_addr, data: head_data,
                 size: head_size, rob: head_rob_id};
        m_req_we    = head_is_store;
        m_req_addr  = exp_addr(head_addr, head_size);
        m_req_be    = exp_be(head_addr, head_size);
        m_req_wdata = exp_wdata(head_data, head_size);
        m_rob       = head_rob_id;
      end
    end else if (m_hs) begin
      if (dc_req_ready) begin
        m_hs = 0;
        if (m_op.st) m_active = 0;
        else if (flush) begin m_active = 0; m_drop = 1; end
        else m_await = 1;
      end else if (flush) begin
        m_hs = 0; m_active = 0;
      end
    end else if (m_await) begin
      if (dc_resp_valid) begin
        m_await = 0;
        if (flush) m_active = 0;
        else begin
          m_wb = 1;
          m_wb_data = exp_load(dc_resp_rdata, m_op.addr, m_op.size, m_op.uns);
        end
      end else if (flush) begin
        m_await = 0; m_active = 0; m_drop = 1;
      end
    end else if (m_wb) begin
      m_wb = 0; m_active = 0;
    end
  endtask

  // One clock: compare mid-cycle, then advance the model with the inputs seen at the edge.
  task automatic step();
    bit e_deq, e_wbv, hs_load;
    @(negedge clk); #1;
    e_deq = (m_hs && dc_req_ready && m_op.st && !flush) || (m_wb && !flush);
    e_wbv = m_wb && !flush;
    chk("busy",         32'(busy),         32'(m_active || m_drop));
    chk("dc_req_valid", 32'(dc_req_valid), 32'(m_hs));
    chk("deq_valid",    32'(deq_valid),    32'(e_deq));
    chk("wb_valid",     32'(wb_valid),     32'(e_wbv));
    chk("dc_req_we",    32'(dc_req_we),    32'(m_req_we));
    chk("dc_req_addr",  dc_req_addr,       m_req_addr);
    chk("dc_req_wdata", dc_req_wdata,      m_req_wdata);
    chk("dc_req_be",    32'(dc_req_be),    32'(m_req_be));
    chk("wb_rob_id",    32'(wb_rob_id),    32'(m_rob));
    chk("wb_data",      wb_data,           m_wb_data);
    s_deq = deq_valid; s_reqv = dc_req_valid; s_wbv = wb_valid; s_busy = busy; s_we = dc_req_we;
    s_addr = dc_req_addr; s_wdata = dc_req_wdata; s_wbd = wb_data; s_be = dc_req_be; s_wbrob = wb_rob_id;
    @(posedge clk); #1;
    hs_load = m_hs && dc_req_ready && !m_op.st;
    if (rand_mode && e_deq && q.size() > 0) q.delete(0);
    if (resp_delay == 0) resp_delay = -1;
    else if (resp_delay > 0) resp_delay--;
    if (rst) model_reset();
    else begin
      if (rand_mode && hs_load) resp_delay = int'($urandom_range(0, 3));
      model_update();
    end
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; head_valid = 0; head_is_store = 0; head_addr_valid = 0; head_unsigned = 0;
    head_addr = '0; head_data = '0; head_size = 2'd2; head_rob_id = '0;
    store_commit = 0; store_commit_rob_id = '0; dc_req_ready = 0; dc_resp_valid = 0; dc_resp_rdata = '0;
  endtask

  task automatic set_head(bit st, logic [31:0] a, logic [31:0] d, logic [1:0] sz, bit uns, logic [RW-1:0] rob);
    head_valid = 1; head_addr_valid = 1; head_is_store = st; head_addr = a; head_data = d;
    head_size = sz; head_unsigned = uns; head_rob_id = rob;
  endtask

  task automatic load_signed_byte(bit uns, logic [31:0] exp);
    set_head(0, 32'h103, 32'h0, 2'd0, uns, 6'd7); dc_req_ready = 1;
    step();
    head_valid = 0;
    step();
    chk("ldb_addr", s_addr, SUBWORD ? 32'h103 : 32'h100);
    chk("ldb_be", 32'(s_be), SUBWORD ? 32'h8 : 32'hF);
    dc_resp_valid = 1; dc_resp_rdata = 32'h80000000;
    step();
    dc_resp_valid = 0;
    step();
    chk("ldb_wb_valid", 32'(s_wbv), 32'd1);
    chk("ldb_wb_data", s_wbd, exp);
    step();
  endtask

  task automatic rand_drive();
    op_t o;
    if (q.size() == 0) begin
      for (int i = 0; i < 8; i++) begin
        o.st   = ($urandom_range(0, 2) == 0);
        o.uns  = ($urandom_range(0, 1) == 1);
        o.addr = $urandom;
        o.data = $urandom;
        o.size = 2'($urandom_range(0, 2));
        o.rob  = RW'($urandom);
        q.push_back(o);
      end
    end
    o = q[0];
    rst             = ($urandom_range(0, 299) == 0);
    flush           = ($urandom_range(0, 24) == 0);
    head_valid      = ($urandom_range(0, 7) != 0);
    head_addr_valid = ($urandom_range(0, 4) != 0);
    head_is_store   = o.st;
    head_unsigned   = o.uns;
    head_addr       = o.addr;
    head_data       = o.data;
    head_size       = o.size;
    head_rob_id     = o.rob;
    store_commit    = ($urandom_range(0, 2) != 0);
    store_commit_rob_id = ($urandom_range(0, 3) != 0) ? o.rob : RW'($urandom);
    dc_req_ready    = ($urandom_range(0, 2) != 0);
    dc_resp_valid   = (resp_delay == 0);
    dc_resp_rdata   = $urandom;
  endtask

  initial begin
    idle_inputs();
    rand_mode = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_req_valid", 32'(s_reqv), 32'd0);
    chk("rst_wb_data", s_wbd, 32'd0);
    rst = 0;
    step();

    // Word load, immediate ready, response two cycles after the handshake.
    set_head(0, 32'h1000, 32'h0, 2'd2, 0, 6'd5); dc_req_ready = 1;
    step();
    head_valid = 0;
    step();
    chk("ld_req_valid", 32'(s_reqv), 32'd1);
    chk("ld_req_addr", s_addr, 32'h1000);
    chk("ld_req_we", 32'(s_we), 32'd0);
    step();
    dc_resp_valid = 1; dc_resp_rdata = 32'hDEADBEEF;
    step();
    chk("ld_wb_early", 32'(s_wbv), 32'd0);
    dc_resp_valid = 0;
    step();
    chk("ld_wb_valid", 32'(s_wbv), 32'd1);
    chk("ld_deq", 32'(s_deq), 32'd1);
    chk("ld_wb_rob", 32'(s_wbrob), 32'd5);
    chk("ld_wb_data", s_wbd, 32'hDEADBEEF);
    step();
    chk("ld_idle", 32'(s_busy), 32'd0);

    // Byte store with matching commit.
    set_head(1, 32'h2004, 32'hAB, 2'd0, 0, 6'd3); store_commit = 1; store_commit_rob_id = 6'd3; dc_req_ready = 1;
    step();
    head_valid = 0; store_commit = 0;
    step();
    chk("st_we", 32'(s_we), 32'd1);
    chk("st_deq", 32'(s_deq), 32'd1);
    chk("st_addr", s_addr, 32'h2004);
    chk("st_be", 32'(s_be), SUBWORD ? 32'h1 : 32'hF);
    chk("st_wdata", s_wdata, SUBWORD ? 32'hABABABAB : 32'h000000AB);
    step();
    chk("st_idle", 32'(s_busy), 32'd0);

    // Store whose commit targets another ROB entry never issues.
    set_head(1, 32'h2008, 32'h55, 2'd2, 0, 6'd3); store_commit = 1; store_commit_rob_id = 6'd4;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("st_blocked_req", 32'(s_reqv), 32'd0);
      chk("st_blocked_busy", 32'(s_busy), 32'd0);
    end
    idle_inputs();

    load_signed_byte(0, SUBWORD ? 32'hFFFFFF80 : 32'h80000000);
    load_signed_byte(1, SUBWORD ? 32'h00000080 : 32'h80000000);
    idle_inputs();

    // Flush while waiting: the late response is swallowed.
    set_head(0, 32'h40, 32'h0, 2'd2, 0, 6'd9); dc_req_ready = 1;
    step();
    head_valid = 0;
    step();
    flush = 1;
    step();
    chk("drain_no_wb", 32'(s_wbv), 32'd0);
    step();
    flush = 0;
    step();
    chk("drain_busy", 32'(s_busy), 32'd1);
    dc_resp_valid = 1; dc_resp_rdata = 32'h12345678;
    step();
    chk("drain_no_deq", 32'(s_deq), 32'd0);
    chk("drain_no_wb2", 32'(s_wbv), 32'd0);
    dc_resp_valid = 0;
    step();
    chk("drain_idle", 32'(s_busy), 32'd0);

    // Flush on a store handshake: store goes out but is not popped.
    set_head(1, 32'h80, 32'h77, 2'd2, 0, 6'd1); store_commit = 1; store_commit_rob_id = 6'd1; dc_req_ready = 1;
    step();
    head_valid = 0; store_commit = 0; flush = 1;
    step();
    chk("stflush_req", 32'(s_reqv), 32'd1);
    chk("stflush_deq", 32'(s_deq), 32'd0);
    flush = 0;
    step();
    chk("stflush_idle", 32'(s_busy), 32'd0);

    // Reset while a request is stalled.
    set_head(0, 32'h3000, 32'h0, 2'd2, 0, 6'd2); dc_req_ready = 0;
    step();
    head_valid = 0;
    step();
    chk("rstmid_req", 32'(s_reqv), 32'd1);
    rst = 1;
    step();
    rst = 0;
    step();
    chk("rstmid_req_after", 32'(s_reqv), 32'd0);
    chk("rstmid_busy", 32'(s_busy), 32'd0);
    chk("rstmid_addr", s_addr, 32'd0);
    step();
    chk("rstmid_req_later", 32'(s_reqv), 32'd0);

    idle_inputs();
    rand_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      rand_drive();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
